// File: rtl/axi_line_fill.sv
// axi_line_fill: fetches one cache line as a single AXI4 INCR read burst
// and presents the assembled line to a consumer. One fill in flight at a time.
`timescale 1ns/1ps
module axi_line_fill #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int BEATS      = 8,
  parameter int FILL_ID    = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ADDR_WIDTH-1:0]       req_addr,
  output logic                        fill_valid,
  input  logic                        fill_ready,
  output logic [BEATS*DATA_WIDTH-1:0] fill_data,
  output logic                        fill_error,
  output logic [ID_WIDTH-1:0]         m_axi_arid,
  output logic [ADDR_WIDTH-1:0]       m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic                        m_axi_arlock,
  output logic [3:0]                  m_axi_arcache,
  output logic [2:0]                  m_axi_arprot,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [ID_WIDTH-1:0]         m_axi_rid,
  input  logic [DATA_WIDTH-1:0]       m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(BEATS * BYTES);
  localparam int SIZE_LOG = $clog2(BYTES);
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]      LAST_IDX  = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);
  localparam logic [ID_WIDTH-1:0]   FILL_ID_V = ID_WIDTH'(FILL_ID);

  // Parameter sanity: reject illegal line geometries at elaboration.
  if (BEATS < 1 || BEATS > 256 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_beats
    $error("axi_line_fill: BEATS must be a power of two in 1..256");
  end
  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("axi_line_fill: DATA_WIDTH must be a non-zero multiple of 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic                    req_ready_r;
  logic                    arvalid_r;
  logic                    rready_r;
  logic                    fill_valid_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [CNT_W-1:0]        beat_cnt_r;
  logic                    full_r;      // slot BEATS-1 already written; later beats are dropped
  logic                    err_r;
  logic [BEATS*DATA_WIDTH-1:0] line_r;

  logic req_hs_s;
  logic ar_hs_s;
  logic r_hs_s;
  logic fill_hs_s;
  logic beat_bad_s;

  assign req_hs_s  = req_valid & req_ready_r;
  assign ar_hs_s   = arvalid_r & m_axi_arready;
  assign r_hs_s    = m_axi_rvalid & rready_r;
  assign fill_hs_s = fill_valid_r & fill_ready;

  // A beat is bad on error response, foreign ID, early RLAST, or overrun.
  assign beat_bad_s = (m_axi_rresp != 2'b00) | (m_axi_rid != FILL_ID_V) |
                      (m_axi_rlast & (beat_cnt_r != LAST_IDX)) | full_r;

  // Next-state decode for the fill sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_hs_s) state_s = ADDR;
        else          state_s = IDLE;
      end
      ADDR: begin
        if (ar_hs_s) state_s = DATA;
        else         state_s = ADDR;
      end
      DATA: begin
        if (r_hs_s && m_axi_rlast) state_s = DONE;
        else                       state_s = DATA;
      end
      DONE: begin
        if (fill_hs_s) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register plus handshake flags registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      req_ready_r  <= 1'b1;
      arvalid_r    <= 1'b0;
      rready_r     <= 1'b0;
      fill_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      req_ready_r  <= (state_s == IDLE);
      arvalid_r    <= (state_s == ADDR);
      rready_r     <= (state_s == DATA);
      fill_valid_r <= (state_s == DONE);
    end
  end

  // Datapath: address capture, beat storage, saturating counter, sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r     <= '0;
      beat_cnt_r <= '0;
      full_r     <= 1'b0;
      err_r      <= 1'b0;
      line_r     <= '0;
    end else if (req_hs_s) begin
      addr_r     <= req_addr & ~OFF_MASK;
      beat_cnt_r <= '0;
      full_r     <= 1'b0;
      err_r      <= 1'b0;
    end else if (r_hs_s) begin
      if (beat_bad_s) begin
        err_r <= 1'b1;
      end
      if (!full_r) begin
        line_r[beat_cnt_r*DATA_WIDTH +: DATA_WIDTH] <= m_axi_rdata;
        if (beat_cnt_r == LAST_IDX) begin
          full_r <= 1'b1;
        end else begin
          beat_cnt_r <= beat_cnt_r + CNT_W'(1);
        end
      end
    end
  end

  assign req_ready     = req_ready_r;
  assign fill_valid    = fill_valid_r;
  assign fill_data     = line_r;
  assign fill_error    = err_r;
  assign m_axi_arvalid = arvalid_r;
  assign m_axi_rready  = rready_r;
  assign m_axi_araddr  = addr_r;
  assign m_axi_arid    = FILL_ID_V;
  assign m_axi_arlen   = 8'(BEATS - 1);
  assign m_axi_arsize  = 3'(SIZE_LOG);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;

endmodule

// File: tb/tb_axi_line_fill.sv
// Bench for axi_line_fill: a behavioural AXI read slave whose memory holds
// word value n at word n, a table of fill scenarios, and a scoreboard that
// checks every AR and every delivered line.
`timescale 1ns/1ps
module tb_axi_line_fill;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int IW = 8;
  localparam int NB = 8;
  localparam int LW = NB * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          fill_valid;
  logic          fill_ready;
  logic [LW-1:0] fill_data;
  logic          fill_error;
  logic [IW-1:0] m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arlock;
  logic [3:0]    m_axi_arcache;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [IW-1:0] m_axi_rid;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic          m_axi_rvalid;
  logic          m_axi_rready;

  axi_line_fill #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .BEATS(NB), .FILL_ID(0)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_data(fill_data), .fill_error(fill_error),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    int            ar_delay;
    int            fr_delay;
    int            err_beat;
    int            last_beat;
    int            bad_id_beat;
    int            abort_after;
    logic [AW-1:0] exp_araddr;
    logic          exp_err;
  } vec_t;

  typedef struct {
    logic [LW-1:0] data;
    logic          err;
  } fill_exp_t;

  fill_exp_t     fill_q[$];
  logic [AW-1:0] ar_q[$];
  logic [LW-1:0] prev_line = '0;

  int n_checks  = 0;
  int n_errors  = 0;
  int ar_count  = 0;
  int slave_txn = 0;

  int cfg_ar_delay    = 0;
  int cfg_err_beat    = -1;
  int cfg_last_beat   = 7;
  int cfg_bad_id_beat = -1;
  int cfg_abort_after = -1;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [AW-1:0] addr, input int ar_d, input int fr_d,
                              input int eb, input int lb, input int ib, input int ab,
                              input logic [AW-1:0] ea, input logic ee);
    vec_t v;
    v.addr = addr; v.ar_delay = ar_d; v.fr_delay = fr_d; v.err_beat = eb;
    v.last_beat = lb; v.bad_id_beat = ib; v.abort_after = ab;
    v.exp_araddr = ea; v.exp_err = ee;
    return v;
  endfunction

  // Reference line: slots up to the last sent beat come from memory, the rest keep old values.
  function automatic logic [LW-1:0] model_line(input logic [AW-1:0] base, input int last,
                                               input logic [LW-1:0] prev);
    logic [LW-1:0] l;
    l = prev;
    for (int k = 0; k < NB; k++) begin
      if (k <= last) l[k*DW +: DW] = 32'(base >> 2) + 32'(k);
    end
    return l;
  endfunction

  // Behavioural AXI read slave.
  initial begin : slave
    logic [AW-1:0] a0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rid = '0;
    forever begin
      @(posedge clk); #1;
      if (m_axi_arvalid && !rst) begin
        a0 = m_axi_araddr;
        for (int d = 0; d < cfg_ar_delay; d++) begin
          chk("ar_hold_valid", {255'd0, m_axi_arvalid}, 256'd1);
          chk("ar_hold_addr", {240'd0, m_axi_araddr}, {240'd0, a0});
          @(posedge clk); #1;
        end
        m_axi_arready = 1'b1;
        @(posedge clk); #1;
        m_axi_arready = 1'b0;
        for (int k = 0; k <= cfg_last_beat; k++) begin
          if (cfg_abort_after >= 0 && k > cfg_abort_after) break;
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = 32'(a0 >> 2) + 32'(k);
          m_axi_rresp  = (k == cfg_err_beat) ? 2'b10 : 2'b00;
          m_axi_rid    = (k == cfg_bad_id_beat) ? 8'h5A : 8'h00;
          m_axi_rlast  = (k == cfg_last_beat);
          chk("rready_in_data", {255'd0, m_axi_rready}, 256'd1);
          @(posedge clk); #1;
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; m_axi_rid = '0;
        if (cfg_abort_after < 0) chk("fill_valid_after_rlast", {255'd0, fill_valid}, 256'd1);
        slave_txn = slave_txn + 1;
      end
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  initial begin : monitor
    logic [AW-1:0] ea;
    fill_exp_t     fe;
    forever begin
      @(negedge clk);
      if (!rst && m_axi_arvalid && m_axi_arready) begin
        ar_count = ar_count + 1;
        chk("ar_fields",
            {227'd0, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot},
            {227'd0, 8'h00, 8'h07, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
        if (ar_q.size() == 0) begin
          chk("ar_unexpected", 256'd1, 256'd0);
        end else begin
          ea = ar_q.pop_front();
          chk("araddr", {240'd0, m_axi_araddr}, {240'd0, ea});
        end
      end
      if (!rst && fill_valid && fill_ready) begin
        if (fill_q.size() == 0) begin
          chk("fill_unexpected", 256'd1, 256'd0);
        end else begin
          fe = fill_q.pop_front();
          chk("fill_data", fill_data, fe.data);
          chk("fill_error", {255'd0, fill_error}, {255'd0, fe.err});
        end
      end
    end
  end

  task automatic do_fill(input vec_t v);
    int            t0;
    int            a0;
    logic [LW-1:0] exp_line;
    logic [LW-1:0] hold;
    fill_exp_t     fe;
    cfg_ar_delay = v.ar_delay; cfg_err_beat = v.err_beat; cfg_last_beat = v.last_beat;
    cfg_bad_id_beat = v.bad_id_beat; cfg_abort_after = v.abort_after;
    t0 = slave_txn;
    a0 = ar_count;
    exp_line = model_line(v.exp_araddr, v.last_beat, prev_line);
    ar_q.push_back(v.exp_araddr);
    if (v.abort_after < 0) begin
      fe.data = exp_line; fe.err = v.exp_err;
      fill_q.push_back(fe);
      prev_line = exp_line;
    end
    fill_ready = (v.fr_delay == 0);
    chk("req_ready_idle", {255'd0, req_ready}, 256'd1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("arvalid_cycle1", {255'd0, m_axi_arvalid}, 256'd1);
    chk("req_ready_busy", {255'd0, req_ready}, 256'd0);
    if (v.abort_after >= 0) begin
      for (int c = 0; c < 200 && slave_txn == t0; c++) begin @(posedge clk); #1; end
      chk("slave_done_abort", {255'd0, slave_txn != t0}, 256'd1);
      rst = 1'b1;
      #1;
      chk("rst_arvalid", {255'd0, m_axi_arvalid}, 256'd0);
      chk("rst_rready", {255'd0, m_axi_rready}, 256'd0);
      chk("rst_fill_valid", {255'd0, fill_valid}, 256'd0);
      chk("rst_fill_error", {255'd0, fill_error}, 256'd0);
      chk("rst_fill_data", fill_data, 256'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("req_ready_after_rst", {255'd0, req_ready}, 256'd1);
      chk("no_fill_after_rst", {255'd0, fill_valid}, 256'd0);
      prev_line = '0;
      fill_ready = 1'b1;
      return;
    end
    for (int c = 0; c < 200 && !fill_valid; c++) begin @(posedge clk); #1; end
    chk("fill_valid_seen", {255'd0, fill_valid}, 256'd1);
    if (v.fr_delay > 0) begin
      hold = fill_data;
      for (int i = 0; i < v.fr_delay; i++) begin
        chk("bp_fill_valid", {255'd0, fill_valid}, 256'd1);
        chk("bp_fill_data", fill_data, hold);
        chk("bp_req_ready", {255'd0, req_ready}, 256'd0);
        chk("bp_no_new_ar", 256'(ar_count), 256'(a0 + 1));
        @(posedge clk); #1;
      end
      fill_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("fill_valid_drop", {255'd0, fill_valid}, 256'd0);
    chk("req_ready_back", {255'd0, req_ready}, 256'd1);
    chk("one_ar", 256'(ar_count), 256'(a0 + 1));
    for (int c = 0; c < 50 && slave_txn == t0; c++) begin @(posedge clk); #1; end
    chk("slave_done", {255'd0, slave_txn != t0}, 256'd1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Main sequence.
  initial begin
    //               addr      ard frd err last  id  abort araddr    err
    vecs[0] = mk(16'h0024, 0,  0,  -1, 7,   -1, -1, 16'h0020, 1'b0); // basic fill
    vecs[1] = mk(16'h013F, 5,  0,  -1, 7,   -1, -1, 16'h0120, 1'b0); // arready backpressure
    vecs[2] = mk(16'h0040, 0,  10, -1, 7,   -1, -1, 16'h0040, 1'b0); // fill_ready backpressure
    vecs[3] = mk(16'h0065, 0,  0,  3,  7,   -1, -1, 16'h0060, 1'b1); // SLVERR on beat 3
    vecs[4] = mk(16'h00A0, 0,  0,  -1, 5,   -1, -1, 16'h00A0, 1'b1); // early rlast on beat 5
    vecs[5] = mk(16'hFFFC, 0,  0,  -1, 9,   -1, -1, 16'hFFE0, 1'b1); // overlong burst
    vecs[6] = mk(16'h0200, 2,  3,  -1, 7,   0,  -1, 16'h0200, 1'b1); // wrong RID on beat 0

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; fill_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", {255'd0, req_ready}, 256'd1);
    chk("reset_arvalid", {255'd0, m_axi_arvalid}, 256'd0);
    chk("reset_rready", {255'd0, m_axi_rready}, 256'd0);
    chk("reset_fill_valid", {255'd0, fill_valid}, 256'd0);
    chk("reset_fill_error", {255'd0, fill_error}, 256'd0);
    chk("reset_fill_data", fill_data, 256'd0);
    chk("reset_araddr", {240'd0, m_axi_araddr}, 256'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) do_fill(vecs[i]);

    // Reset after beat 2, then a fresh request must complete cleanly.
    do_fill(mk(16'h0300, 0, 0, -1, 7, -1, 2, 16'h0300, 1'b0));
    do_fill(mk(16'h0047, 0, 0, -1, 7, -1, -1, 16'h0040, 1'b0));

    repeat (3) @(posedge clk);
    #1;
    chk("fill_q_empty", 256'(fill_q.size()), 256'd0);
    chk("ar_q_empty", 256'(ar_q.size()), 256'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
